// File: rtl/mc_sequencer_if.sv
// Sequencer-facing bundle: decoder enables and memory/mul-div handshakes in,
// phase-gated strobes, state and retired count out.
interface mc_sequencer_if #(
  parameter int CNT_W = 32
);
  logic             dec_reg_w;
  logic             dec_dm_r;
  logic             dec_dm_w;
  logic             dec_hi_w;
  logic             dec_lo_w;
  logic             dec_md;
  logic             dec_eret;
  logic             dec_exc;
  logic [4:0]       dec_cause;
  logic             mem_ready;
  logic             md_done;
  logic             irq;

  logic             ir_w;
  logic             pc_w;
  logic [1:0]       pc_sel;
  logic             reg_w;
  logic             dm_r;
  logic             dm_w;
  logic             hi_w;
  logic             lo_w;
  logic             md_start;
  logic             exc_w;
  logic [4:0]       exc_cause;
  logic [2:0]       state;
  logic [CNT_W-1:0] instret;

  modport master (
    input  dec_reg_w, dec_dm_r, dec_dm_w, dec_hi_w, dec_lo_w, dec_md,
           dec_eret, dec_exc, dec_cause, mem_ready, md_done, irq,
    output ir_w, pc_w, pc_sel, reg_w, dm_r, dm_w, hi_w, lo_w, md_start,
           exc_w, exc_cause, state, instret
  );

  modport slave (
    output dec_reg_w, dec_dm_r, dec_dm_w, dec_hi_w, dec_lo_w, dec_md,
           dec_eret, dec_exc, dec_cause, mem_ready, md_done, irq,
    input  ir_w, pc_w, pc_sel, reg_w, dm_r, dm_w, hi_w, lo_w, md_start,
           exc_w, exc_cause, state, instret
  );
endinterface

// File: rtl/mc_sequencer.sv
// Multi-cycle IF/ID/EX/MEM/WB sequencer with memory/mul-div wait states,
// bus-timeout exception and retired-instruction counter. Optional MC_SEQ_IRQ_EN.
module mc_sequencer #(
  parameter int         MEM_TIMEOUT = 16,
  parameter int         CNT_W       = 32,
  parameter logic [4:0] BUS_CAUSE   = 5'b00111,
  parameter logic [4:0] IRQ_CAUSE   = 5'b00000
) (
  input logic           clk,
  input logic           rst_n,
  mc_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4,
    S_MDW = 3'd5,
    S_EXC = 3'd6
  } state_t;

  localparam int                WAIT_W    = $clog2(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_t             state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [4:0]         cause_q, cause_d;
  logic [CNT_W-1:0]   instret_q;

  logic       ir_w, pc_w, reg_w, dm_r, dm_w, hi_w, lo_w, md_start, exc_w;
  logic [1:0] pc_sel;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IF;
      wait_q    <= '0;
      cause_q   <= '0;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      cause_q <= cause_d;
      if (pc_w && (state_q != S_EXC))
        instret_q <= instret_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    cause_d  = cause_q;
    ir_w     = 1'b0;
    pc_w     = 1'b0;
    pc_sel   = 2'd0;
    reg_w    = 1'b0;
    dm_r     = 1'b0;
    dm_w     = 1'b0;
    hi_w     = 1'b0;
    lo_w     = 1'b0;
    md_start = 1'b0;
    exc_w    = 1'b0;

    case (state_q)
      S_IF: begin
`ifdef MC_SEQ_IRQ_EN
        if (bus.irq) begin
          cause_d = IRQ_CAUSE;
          state_d = S_EXC;
        end else begin
          ir_w    = 1'b1;
          state_d = S_ID;
        end
`else
        ir_w    = 1'b1;
        state_d = S_ID;
`endif
      end

      S_ID: begin
        if (bus.dec_exc) begin
          cause_d = bus.dec_cause;
          state_d = S_EXC;
        end else begin
          state_d = S_EX;
        end
      end

      S_EX: begin
        if (bus.dec_md) begin
          md_start = 1'b1;
          state_d  = S_MDW;
        end else if (bus.dec_dm_r || bus.dec_dm_w) begin
          wait_d  = '0;
          state_d = S_MEM;
        end else if (bus.dec_eret) begin
          pc_w    = 1'b1;
          pc_sel  = 2'd2;
          state_d = S_IF;
        end else if (bus.dec_reg_w) begin
          state_d = S_WB;
        end else begin
          pc_w    = 1'b1;
          hi_w    = bus.dec_hi_w;
          lo_w    = bus.dec_lo_w;
          state_d = S_IF;
        end
      end

      // The request stays up through the final wait cycle; completion on that
      // same cycle still beats the timeout.
      S_MEM: begin
        dm_r = bus.dec_dm_r;
        dm_w = bus.dec_dm_w;
        if (bus.mem_ready) begin
          if (bus.dec_dm_r) begin
            state_d = S_WB;
          end else begin
            pc_w    = 1'b1;
            state_d = S_IF;
          end
        end else if (wait_q == WAIT_LAST) begin
          cause_d = BUS_CAUSE;
          state_d = S_EXC;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end

      S_MDW: begin
        if (bus.md_done) begin
          hi_w    = bus.dec_hi_w;
          lo_w    = bus.dec_lo_w;
          pc_w    = 1'b1;
          state_d = S_IF;
        end
      end

      S_WB: begin
        reg_w   = 1'b1;
        pc_w    = 1'b1;
        state_d = S_IF;
      end

      S_EXC: begin
        exc_w   = 1'b1;
        pc_w    = 1'b1;
        pc_sel  = 2'd1;
        state_d = S_IF;
      end

      default: state_d = S_IF;
    endcase
  end

  // Strobes are forced quiet while reset is held, even before the state register clears.
  assign bus.ir_w      = rst_n & ir_w;
  assign bus.pc_w      = rst_n & pc_w;
  assign bus.pc_sel    = rst_n ? pc_sel : 2'd0;
  assign bus.reg_w     = rst_n & reg_w;
  assign bus.dm_r      = rst_n & dm_r;
  assign bus.dm_w      = rst_n & dm_w;
  assign bus.hi_w      = rst_n & hi_w;
  assign bus.lo_w      = rst_n & lo_w;
  assign bus.md_start  = rst_n & md_start;
  assign bus.exc_w     = rst_n & exc_w;
  assign bus.exc_cause = (rst_n && exc_w) ? cause_q : 5'd0;
  assign bus.state     = state_q;
  assign bus.instret   = instret_q;

`ifndef MC_SEQ_IRQ_EN
  logic [5:0] unused_irq;
  assign unused_irq = {bus.irq, IRQ_CAUSE};
`endif

endmodule

// File: tb/tb_mc_sequencer.sv
// Scoreboard bench for mc_sequencer: a per-instruction timing/strobe model feeds
// a queue, and an independent monitor checks each pc_w event against it.
module tb_mc_sequencer;

  localparam int         MEM_TIMEOUT = 16;
  localparam int         CNT_W       = 6;
  localparam logic [4:0] BUS_CAUSE   = 5'b00111;
  localparam logic [4:0] IRQ_CAUSE   = 5'b00000;

  localparam int K_ALU = 0, K_LW = 1, K_SW = 2, K_BR = 3, K_MD = 4,
                 K_ERET = 5, K_SYS = 6, K_LWTO = 7, K_SWTO = 8, K_IRQ = 9;

  typedef struct {
    int lat;
    int fin;
    int n_ir;
    int n_dmr;
    int n_dmw;
    int n_mds;
    int n_reg;
    int n_hi;
    int n_lo;
    int n_exc;
    int pc_sel;
    int cause;
    int instret;
  } exp_t;

  logic clk;
  logic rst_n;
  mc_sequencer_if #(.CNT_W(CNT_W)) bus();

  mc_sequencer #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .CNT_W      (CNT_W),
    .BUS_CAUSE  (BUS_CAUSE),
    .IRQ_CAUSE  (IRQ_CAUSE)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t sb_q[$];
  int   tests_run    = 0;
  int   tests_failed = 0;
  int   model_instret = 0;

  task automatic checkOutput(input string name, input int act, input int exp);
    tests_run++;
    if (act != exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic setDecoder(input logic rw, input logic dr, input logic dw,
                            input logic hw, input logic lw, input logic md,
                            input logic er, input logic ex, input logic [4:0] cs);
    bus.dec_reg_w = rw;
    bus.dec_dm_r  = dr;
    bus.dec_dm_w  = dw;
    bus.dec_hi_w  = hw;
    bus.dec_lo_w  = lw;
    bus.dec_md    = md;
    bus.dec_eret  = er;
    bus.dec_exc   = ex;
    bus.dec_cause = cs;
  endtask

  // Reference model: whole-instruction latency and strobe totals from the phase rules,
  // then a cycle-by-cycle drive of the handshakes at the times the model chose.
  task automatic applyStimulus(input int kind, input int k, input logic [4:0] cause);
    exp_t e;
    logic rw, dr, dw, hw, lw, md, er, ex, retire;
    int   mem_at, md_at;
    e = '{default: 0};
    e.n_ir    = 1;
    e.instret = model_instret;
    rw = 1'b0; dr = 1'b0; dw = 1'b0; md = 1'b0; er = 1'b0; ex = 1'b0;
    hw = 1'($urandom); lw = 1'($urandom);
    mem_at = -1; md_at = -1; retire = 1'b1;
    case (kind)
      K_ALU:  begin rw = 1'b1; e.lat = 4; e.fin = 4; e.n_reg = 1; end
      K_LW:   begin rw = 1'b1; dr = 1'b1; mem_at = 3 + k; e.lat = 5 + k; e.fin = 4;
                    e.n_reg = 1; e.n_dmr = k + 1; end
      K_SW:   begin dw = 1'b1; mem_at = 3 + k; e.lat = 4 + k; e.fin = 3; e.n_dmw = k + 1; end
      K_BR:   begin e.lat = 3; e.fin = 2; e.n_hi = int'(hw); e.n_lo = int'(lw); end
      K_MD:   begin md = 1'b1; rw = 1'($urandom); md_at = 3 + k; e.lat = 4 + k; e.fin = 5;
                    e.n_mds = 1; e.n_hi = int'(hw); e.n_lo = int'(lw); end
      K_ERET: begin er = 1'b1; rw = 1'($urandom); e.lat = 3; e.fin = 2; e.pc_sel = 2; end
      K_SYS:  begin ex = 1'b1; rw = 1'($urandom); dr = 1'($urandom); dw = 1'($urandom);
                    md = 1'($urandom); er = 1'($urandom); e.lat = 3; e.fin = 6;
                    e.n_exc = 1; e.pc_sel = 1; e.cause = int'(cause); retire = 1'b0; end
      K_LWTO: begin rw = 1'b1; dr = 1'b1; e.lat = 4 + MEM_TIMEOUT; e.fin = 6;
                    e.n_dmr = MEM_TIMEOUT; e.n_exc = 1; e.pc_sel = 1;
                    e.cause = int'(BUS_CAUSE); retire = 1'b0; end
      K_SWTO: begin dw = 1'b1; e.lat = 4 + MEM_TIMEOUT; e.fin = 6;
                    e.n_dmw = MEM_TIMEOUT; e.n_exc = 1; e.pc_sel = 1;
                    e.cause = int'(BUS_CAUSE); retire = 1'b0; end
      default: begin rw = 1'($urandom); md = 1'($urandom); e.lat = 2; e.fin = 6; e.n_ir = 0;
                    e.n_exc = 1; e.pc_sel = 1; e.cause = int'(IRQ_CAUSE); retire = 1'b0; end
    endcase
    sb_q.push_back(e);
    if (retire) model_instret = (model_instret + 1) % (1 << CNT_W);

    for (int c = 0; c < e.lat; c++) begin
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      if (c == 0) setDecoder(rw, dr, dw, hw, lw, md, er, ex, cause);
      bus.mem_ready = (c < 3) ? 1'($urandom) : (c == mem_at);
      bus.md_done   = (c < 3) ? 1'($urandom) : (c == md_at);
`ifdef MC_SEQ_IRQ_EN
      bus.irq = (c == 0) ? (kind == K_IRQ) : 1'($urandom);
`else
      bus.irq = 1'($urandom);
`endif
    end
  endtask

  // Start a multi-cycle instruction, then pull reset one cycle while it is waiting.
  task automatic applyMidReset(input int kind);
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      if (c == 0)
        setDecoder(1'b0, 1'b0, kind == K_SW, 1'b1, 1'b1, kind == K_MD, 1'b0, 1'b0, 5'd0);
      bus.mem_ready = 1'b0;
      bus.md_done   = 1'b0;
      bus.irq       = 1'b0;
    end
    @(posedge clk);
    #1;
    rst_n         = 1'b0;
    bus.mem_ready = 1'b1;
    bus.md_done   = 1'b1;
    model_instret = 0;
  endtask

  // Monitor: accumulates strobe activity per instruction and checks on each pc_w.
  initial begin : monitor
    int   cyc, n_ir, n_dmr, n_dmw, n_mds, n_reg, n_hi, n_lo, n_exc, act_cause;
    bit   was_reset;
    exp_t e;
    cyc = 0; n_ir = 0; n_dmr = 0; n_dmw = 0; n_mds = 0; n_reg = 0;
    n_hi = 0; n_lo = 0; n_exc = 0; act_cause = 0; was_reset = 1'b0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        checkOutput("reset_strobes",
                    int'({bus.ir_w, bus.pc_w, bus.reg_w, bus.dm_r, bus.dm_w,
                          bus.hi_w, bus.lo_w, bus.md_start, bus.exc_w}), 0);
        checkOutput("reset_pc_sel", int'(bus.pc_sel), 0);
        cyc = 0; n_ir = 0; n_dmr = 0; n_dmw = 0; n_mds = 0; n_reg = 0;
        n_hi = 0; n_lo = 0; n_exc = 0; act_cause = 0;
        was_reset = 1'b1;
      end else begin
        if (was_reset) begin
          checkOutput("post_reset_state", int'(bus.state), 0);
          checkOutput("post_reset_instret", int'(bus.instret), 0);
          was_reset = 1'b0;
        end
        cyc++;
        n_ir  += int'(bus.ir_w);
        n_dmr += int'(bus.dm_r);
        n_dmw += int'(bus.dm_w);
        n_mds += int'(bus.md_start);
        n_reg += int'(bus.reg_w);
        n_hi  += int'(bus.hi_w);
        n_lo  += int'(bus.lo_w);
        n_exc += int'(bus.exc_w);
        if (bus.exc_w) act_cause = int'(bus.exc_cause);
        if (bus.pc_w) begin
          if (sb_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL unexpected_pc_w: got pc_w at state %0d, expected none", bus.state);
          end else begin
            e = sb_q.pop_front();
            checkOutput("latency", cyc, e.lat);
            checkOutput("final_state", int'(bus.state), e.fin);
            checkOutput("pc_sel", int'(bus.pc_sel), e.pc_sel);
            checkOutput("instret", int'(bus.instret), e.instret);
            checkOutput("ir_w_count", n_ir, e.n_ir);
            checkOutput("dm_r_cycles", n_dmr, e.n_dmr);
            checkOutput("dm_w_cycles", n_dmw, e.n_dmw);
            checkOutput("md_start_count", n_mds, e.n_mds);
            checkOutput("reg_w_count", n_reg, e.n_reg);
            checkOutput("hi_w_count", n_hi, e.n_hi);
            checkOutput("lo_w_count", n_lo, e.n_lo);
            checkOutput("exc_w_count", n_exc, e.n_exc);
            if (e.n_exc != 0) checkOutput("exc_cause", act_cause, e.cause);
          end
          cyc = 0; n_ir = 0; n_dmr = 0; n_dmw = 0; n_mds = 0; n_reg = 0;
          n_hi = 0; n_lo = 0; n_exc = 0; act_cause = 0;
        end else if (cyc > 200) begin
          tests_run++;
          tests_failed++;
          $display("[TB] FAIL watchdog: got %0d cycles without pc_w, expected at most 200", cyc);
          $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
          $finish;
        end
      end
    end
  end

  initial begin : stimulus
    int kind, k, nkinds;
    rst_n = 1'b0;
    setDecoder(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    bus.mem_ready = 1'b0;
    bus.md_done   = 1'b0;
    bus.irq       = 1'b0;
    repeat (3) @(posedge clk);

    applyStimulus(K_ALU, 0, 5'd0);
    applyStimulus(K_LW, 3, 5'd0);
    applyStimulus(K_SWTO, 0, 5'd0);
    applyStimulus(K_MD, 32, 5'd0);
    applyStimulus(K_SYS, 0, 5'b01000);
    applyStimulus(K_ERET, 0, 5'd0);
    applyMidReset(K_MD);
    applyStimulus(K_ALU, 0, 5'd0);
    applyMidReset(K_SW);
    applyStimulus(K_LW, MEM_TIMEOUT - 1, 5'd0);
    applyStimulus(K_SW, MEM_TIMEOUT - 1, 5'd0);
    applyStimulus(K_LWTO, 0, 5'd0);
`ifdef MC_SEQ_IRQ_EN
    applyStimulus(K_IRQ, 0, 5'd0);
    nkinds = 10;
`else
    nkinds = 9;
`endif

    for (int i = 0; i < 160; i++) begin
      kind = int'($urandom_range(0, nkinds - 1));
      if (kind == K_LW || kind == K_SW)
        k = ($urandom_range(0, 7) == 0) ? MEM_TIMEOUT - 1 : int'($urandom_range(0, 5));
      else if (kind == K_MD)
        k = int'($urandom_range(0, 40));
      else
        k = 0;
      applyStimulus(kind, k, 5'($urandom));
    end

    @(posedge clk);
    #1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("scoreboard_drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mc_sequencer.md
Name: mc_sequencer

Overview:
- Multi-cycle instruction sequencer for the 54-instruction MIPS core.
- The combinational decoder keeps producing the raw per-instruction enables. This block turns them into phase-gated strobes across IF/ID/EX/MEM/WB.
- Adds wait-states for data memory and the iterative mul/div unit, plus a memory-timeout bus error, exception entry and a retired-instruction counter.

Parameters:
MEM_TIMEOUT, 16, max cycles MEM waits for mem_ready before raising bus error (>=2)
CNT_W, 32, width of retired-instruction counter
BUS_CAUSE, 5'b00111, cause code reported on memory timeout
IRQ_CAUSE, 5'b00000, cause code for external interrupt (IRQ_EN only)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
dec_reg_w  in  1  decoded: instruction writes RegFile
dec_dm_r  in  1  decoded: load
dec_dm_w  in  1  decoded: store
dec_hi_w  in  1  decoded: writes HI
dec_lo_w  in  1  decoded: writes LO
dec_md  in  1  decoded: MULT/MULTU/DIV/DIVU (iterative unit)
dec_eret  in  1  decoded: ERET
dec_exc  in  1  decoded: SYSCALL/BREAK/taken TEQ
dec_cause  in  5  cause code accompanying dec_exc
mem_ready  in  1  data memory completes access this cycle
md_done  in  1  mul/div result valid this cycle
irq  in  1  external interrupt request (used only with IRQ_EN)
ir_w  out  1  latch instruction register
pc_w  out  1  commit next PC
pc_sel  out  2  0 = decoder next-PC, 1 = exception vector, 2 = EPC
reg_w  out  1  RegFile write strobe
dm_r  out  1  data memory read request
dm_w  out  1  data memory write request
hi_w  out  1  HI write strobe
lo_w  out  1  LO write strobe
md_start  out  1  one-cycle start pulse to mul/div
exc_w  out  1  CP0 exception-entry strobe (save EPC/cause)
exc_cause  out  5  cause valid while exc_w = 1
state  out  3  current state encoding
instret  out  CNT_W  retired-instruction count

Behaviour:
- State encoding: IF = 0, ID = 1, EX = 2, MEM = 3, WB = 4, MDW = 5, EXC = 6. Code 7 is illegal and returns to IF.
- Only state and counters are registered; outputs are decoded from state and inputs.
- Reset (rst_n low at a clock edge): state = IF, wait counter = 0, instret = 0, latched cause = 0.
  - All strobes are 0 while rst_n is low; pc_sel = 0.
  - Reset mid-access abandons any MEM or MDW wait immediately.
- IF: ir_w = 1 for one cycle, then ID.
- ID: no strobes. If dec_exc = 1, latch dec_cause and go to EXC; else go to EX.
- EX, checked in priority order:
  - dec_md: md_start = 1, go to MDW.
  - dec_dm_r or dec_dm_w: go to MEM, clear wait counter.
  - dec_eret: pc_w = 1, pc_sel = 2, go to IF.
  - dec_reg_w: go to WB.
  - otherwise (branch/jump/MTHI/MTLO etc.): pc_w = 1, apply dec_hi_w/dec_lo_w as hi_w/lo_w, go to IF.
- MEM:
  - dm_r = dec_dm_r and dm_w = dec_dm_w, held every cycle until mem_ready.
  - On mem_ready: load goes to WB; store asserts pc_w and goes to IF.
  - Without mem_ready the counter increments. If counter == MEM_TIMEOUT-1 and mem_ready = 0, latch BUS_CAUSE, drop dm_r/dm_w and go to EXC.
  - mem_ready on the timeout cycle wins over the timeout.
- MDW:
  - Wait indefinitely for md_done; md_start is never re-pulsed.
  - On md_done: hi_w = dec_hi_w, lo_w = dec_lo_w, pc_w = 1, go to IF.
- WB: reg_w = 1, pc_w = 1, go to IF.
- EXC: exc_w = 1, exc_cause = latched cause, pc_w = 1, pc_sel = 1, go to IF.
- instret increments by 1 on every pc_w cycle except in EXC, and wraps modulo 2^CNT_W.
- Latencies in cycles:
  - ALU: 4.
  - Load: 5 + memory waits.
  - Store: 4 + memory waits.
  - Branch: 3.
  - Mul/div: 4 + cycles until md_done.
- Decoder inputs must stay stable from ID until the instruction retires; they are sourced from the IR.

Optional Feature:
- Macro: MC_SEQ_IRQ_EN.
- Defined:
  - In IF, irq = 1 suppresses ir_w, latches IRQ_CAUSE and goes to EXC; EPC saves the un-fetched PC.
  - irq is sampled only in IF, so in-flight instructions always complete.
  - irq and reset are never simultaneous concerns: reset dominates.
- Undefined: irq is ignored; the port remains for a pin-compatible top level.

Test Plan:
- ADD (dec_reg_w = 1): reset, release rst_n -> state 0,1,2,4,0; reg_w and pc_w high in cycle 4 only; instret = 1.
- LW with mem_ready arriving 3 cycles after MEM entry -> dm_r high 4 cycles, then WB with reg_w = 1; instret increments once.
- SW with mem_ready never asserted, MEM_TIMEOUT = 16 -> dm_w high exactly 16 cycles, then EXC with exc_w = 1, exc_cause = 5'b00111, pc_sel = 1; instret unchanged.
- MULT, md_done after 32 cycles -> md_start pulses once in EX; hi_w = lo_w = 1 with pc_w on the md_done cycle; back to IF.
- SYSCALL (dec_exc = 1, dec_cause = 5'b01000) -> ID goes to EXC, exc_cause = 01000; then ERET -> pc_sel = 2, pc_w in EX.
- rst_n low for one cycle while in MDW -> next state IF, all strobes 0, instret = 0. With MC_SEQ_IRQ_EN, irq high in IF -> no ir_w, EXC with cause 0.
